morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receiver for the on-board Morse link: samples a hand-keyed Morse input on `KEY[1]`, classifies each press as dot or dash, and detects the end of each letter from the idle gap.
- Decodes the completed symbol sequence to one of the eight supported letters A–H, using the same 3-bit letter code the transmitter uses on `SW`.
- Drives the result onto `LEDR`; sits on the same slow tick clock as the transmitter, so one `CLK` period is one Morse time unit.

Parameters:
- `DASH_MIN`, 2: minimum press length in cycles counted as a dash; shorter presses are dots.
- `MAX_PRESS`, 4: longest legal press in cycles; longer presses are an error.
- `LETTER_GAP`, 3: number of consecutive released cycles that ends a letter.
- `CNT_W`, 8: width of the duration counter, which saturates at all-ones.

Ports:
- `CLK` input 1: unit-time clock; all logic on rising edge.
- `KEY` input 2:
  - `KEY[0]` is the asynchronous, active-low reset.
  - `KEY[1]` is the Morse key, high = pressed, asynchronous to `CLK`.
- `LEDR` output 5:
  - `[2:0]` decoded letter code (000=A … 111=H).
  - `[3]` letter-valid, a one-cycle pulse.
  - `[4]` decode error, held until the next letter completes.

Behaviour:
- **Reset:** `KEY[0]` low asynchronously clears everything. State = IDLE; counter, symbol shift register, symbol length, error flag, synchronizer flops and `LEDR` all go to 0.
- **Synchronizer:** `KEY[1]` passes through 2 flops to give `key_s`. All decisions use `key_s` and its registered previous value. Input-to-`key_s` latency is 2 cycles; press and gap lengths are preserved.
- **Counter:** `cnt` counts sampled cycles of the current mark or space. It is set to 1 on entry to MARK or SPACE and increments each cycle after that. It saturates at 2^`CNT_W`-1 and never wraps.
- **Symbol encoding:** the symbol register holds up to 4 symbols, first symbol in the MSB of the used length; dot=0, dash=1.
- **IDLE:**
  - `key_s` rising → MARK, `cnt`=1.
  - Otherwise stay.
- **MARK:**
  - While `key_s`=1, `cnt`++.
  - On `key_s` falling, classify the press:
    - `cnt` < `DASH_MIN` → append dot.
    - `DASH_MIN` ≤ `cnt` ≤ `MAX_PRESS` → append dash.
    - `cnt` > `MAX_PRESS` → set error flag, append nothing.
  - If length is already 4 when appending, set error flag (overflow) and leave register and length unchanged.
  - After classifying → SPACE, `cnt`=1.
- **SPACE:**
  - `key_s`=1 → MARK, `cnt`=1 (next symbol of the same letter).
  - Otherwise `cnt`++; when `cnt` reaches `LETTER_GAP` → EMIT on the next cycle.
- **EMIT (exactly one cycle):**
  - If the error flag is clear and (length, code) matches the table: `LEDR[2:0]`=letter, `LEDR[3]`=1 this cycle only, `LEDR[4]`=0.
  - Otherwise: `LEDR[3]`=0, `LEDR[4]`=1, `LEDR[2:0]` keeps its previous value.
  - In either case clear the register, length and error flag.
  - Next state: `key_s`=1 in the EMIT cycle → MARK with `cnt`=1 (press not lost); else IDLE.
- **Decode table (length:code):**
  - A = 2:01
  - B = 4:1000
  - C = 4:1010
  - D = 3:100
  - E = 1:0
  - F = 4:0010
  - G = 3:110
  - H = 4:0000
  - Any other combination is an error.
- **Output hold rules:**
  - `LEDR[3]` is 0 outside EMIT.
  - `LEDR[2:0]` and `LEDR[4]` hold until the next EMIT.
- **Boundary cases:**
  - A press held indefinitely stays in MARK; the error is raised only at release.
  - A gap longer than `LETTER_GAP` in IDLE has no effect.
  - Reset asserted mid-letter discards the partial letter, with no EMIT.

Test Plan (defaults `DASH_MIN`=2, `MAX_PRESS`=4, `LETTER_GAP`=3; durations in `CLK` cycles at `KEY[1]`):
- Reset, then press 1, release 1, press 2, release 4 → one-cycle pulse `LEDR[3]`=1 with `LEDR[2:0]`=000 (A), `LEDR[4]`=0; `LEDR[3]` low afterwards.
- Press 2, release 1, press 1, release 1, press 2, release 1, press 1, release 4 → `LEDR[2:0]`=010 (C), pulse on `LEDR[3]`; then a single press 1, release 4 → `LEDR[2:0]`=100 (E).
- Press 5, release 4 (over-long press) → `LEDR[4]`=1, `LEDR[3]` stays 0, `LEDR[2:0]` unchanged from the prior letter; next valid letter clears `LEDR[4]`.
- Five dots (1 on / 1 off each), then release 4 → overflow error, `LEDR[4]`=1, no valid pulse.
- Press 2, press 2 (--, not in table), release 4 → `LEDR[4]`=1; then press 1 ×4 (H) → `LEDR[2:0]`=111, `LEDR[4]`=0.
- Mid-letter (after press 2, release 1), assert `KEY[0]` low for 1 cycle → `LEDR`=00000 immediately; a following single press 1, release 4 decodes as E (100), with no leftover symbols.

Source files
------------

// File: rtl/morse_decoder_if.sv
// rtl/morse_decoder_if.sv - LED result bus of the Morse receiver
interface morse_decoder_if;
    logic [4:0] ledr;

    modport master (output ledr);
    modport slave  (input  ledr);
endinterface

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - Morse key receiver: dot/dash timing, letter gap detection, A-H decode
module morse_decoder #(
    parameter int DASH_MIN   = 2,
    parameter int MAX_PRESS  = 4,
    parameter int LETTER_GAP = 3,
    parameter int CNT_W      = 8
) (
    input  logic              CLK,
    input  logic [1:0]        KEY,
    morse_decoder_if.master   LEDR
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;
    localparam logic [1:0] S_EMIT  = 2'd3;

    logic             rst_n;
    logic             key_m_q, key_s_q, key_p_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       sym_q, sym_d;
    logic [2:0]       len_q, len_d;
    logic             err_q, err_d;
    logic [2:0]       letter_q, letter_d;
    logic             valid_q, valid_d;
    logic             dec_err_q, dec_err_d;
    logic             hit;
    logic [2:0]       hit_code;

    assign rst_n   = KEY[0];
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // Symbols are shifted in at the LSB, so the first one ends up at bit len-1.
    always_comb begin
        hit      = 1'b1;
        hit_code = 3'd0;
        case ({len_q, sym_q})
            {3'd2, 4'b0001}: hit_code = 3'd0;
            {3'd4, 4'b1000}: hit_code = 3'd1;
            {3'd4, 4'b1010}: hit_code = 3'd2;
            {3'd3, 4'b0100}: hit_code = 3'd3;
            {3'd1, 4'b0000}: hit_code = 3'd4;
            {3'd4, 4'b0010}: hit_code = 3'd5;
            {3'd3, 4'b0110}: hit_code = 3'd6;
            {3'd4, 4'b0000}: hit_code = 3'd7;
            default:         hit      = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sym_d     = sym_q;
        len_d     = len_q;
        err_d     = err_q;
        letter_d  = letter_q;
        valid_d   = 1'b0;
        dec_err_d = dec_err_q;
        case (state_q)
            S_IDLE: begin
                if (key_s_q && !key_p_q) begin
                    state_d = S_MARK;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_MARK: begin
                if (key_s_q) begin
                    cnt_d = cnt_inc;
                end else begin
                    if (cnt_q > CNT_W'(MAX_PRESS) || len_q == 3'd4) begin
                        err_d = 1'b1;
                    end else begin
                        sym_d = {sym_q[2:0], cnt_q >= CNT_W'(DASH_MIN)};
                        len_d = len_q + 3'd1;
                    end
                    state_d = S_SPACE;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_SPACE: begin
                if (key_s_q) begin
                    state_d = S_MARK;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_inc;
                    // Result registers load on the way into EMIT so LEDR shows it during EMIT.
                    if (cnt_inc >= CNT_W'(LETTER_GAP)) begin
                        state_d = S_EMIT;
                        if (!err_q && hit) begin
                            letter_d  = hit_code;
                            valid_d   = 1'b1;
                            dec_err_d = 1'b0;
                        end else begin
                            dec_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                sym_d = 4'd0;
                len_d = 3'd0;
                err_d = 1'b0;
                if (key_s_q) begin
                    state_d = S_MARK;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            key_m_q   <= 1'b0;
            key_s_q   <= 1'b0;
            key_p_q   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sym_q     <= 4'd0;
            len_q     <= 3'd0;
            err_q     <= 1'b0;
            letter_q  <= 3'd0;
            valid_q   <= 1'b0;
            dec_err_q <= 1'b0;
        end else begin
            key_m_q   <= KEY[1];
            key_s_q   <= key_m_q;
            key_p_q   <= key_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sym_q     <= sym_d;
            len_q     <= len_d;
            err_q     <= err_d;
            letter_q  <= letter_d;
            valid_q   <= valid_d;
            dec_err_q <= dec_err_d;
        end
    end

    assign LEDR.ledr = {dec_err_q, valid_q, letter_q};
endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - table, corner-case and randomized checks of morse_decoder
module tb_morse_decoder;
    logic       clk = 1'b0;
    logic       key_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic [1:0] key_bus;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         pulses;

    assign key_bus = {key_in, rst_n_in};

    morse_decoder_if led_bus ();

    morse_decoder dut (
        .CLK  (clk),
        .KEY  (key_bus),
        .LEDR (led_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] presses;
        logic [4:0]  exp_ledr;
        int          exp_pulses;
    } vec_t;

    typedef struct {
        int         idx;
        bit         ok;
        logic [2:0] code;
    } ev_t;

    int tlen  [8] = '{2, 4, 4, 3, 1, 4, 3, 4};
    int tcode [8] = '{1, 8, 10, 4, 0, 2, 6, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic k, output logic [4:0] s);
        key_in = k;
        @(posedge clk);
        #1;
        s = led_bus.ledr;
        if (s[3]) pulses++;
    endtask

    // Presses of one letter (4-bit nibbles, zero terminated) with one-cycle gaps,
    // then six released cycles; the result is sampled on the fifth.
    task automatic play_letter(input logic [23:0] pr, output logic [4:0] at_emit, output logic [4:0] after);
        logic [4:0] s;
        int p;
        for (int i = 0; i < 6; i++) begin
            p = int'(pr[i*4 +: 4]);
            if (p == 0) break;
            if (i > 0) drive(1'b0, s);
            for (int j = 0; j < p; j++) drive(1'b1, s);
        end
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, s);
            if (j == 4) at_emit = s;
            if (j == 5) after = s;
        end
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        key_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_in = 1'b1;
    endtask

    initial begin
        vec_t       vecs[$];
        logic [4:0] s, at_emit, after;
        bit         kq[$];
        ev_t        evq[$];
        ev_t        ev;
        int         n, code, p, li, ei;
        bit         bad, ok;
        logic [2:0] hl;
        logic       he;

        vecs.push_back('{24'h000021,  5'b01000, 1});
        vecs.push_back('{24'h001212,  5'b01010, 1});
        vecs.push_back('{24'h000001,  5'b01100, 1});
        vecs.push_back('{24'h000005,  5'b10100, 0});
        vecs.push_back('{24'h000122,  5'b01110, 1});
        vecs.push_back('{24'h011111,  5'b10110, 0});
        vecs.push_back('{24'h000022,  5'b10110, 0});
        vecs.push_back('{24'h001111,  5'b01111, 1});
        vecs.push_back('{24'h001113,  5'b01001, 1});
        vecs.push_back('{24'h000114,  5'b01011, 1});
        vecs.push_back('{24'h001211,  5'b01101, 1});

        rst_n_in = 1'b0;
        #1;
        check("reset_async", {27'd0, led_bus.ledr}, 32'd0);
        do_reset();
        check("reset_state", {27'd0, led_bus.ledr}, 32'd0);

        foreach (vecs[i]) begin
            pulses = 0;
            play_letter(vecs[i].presses, at_emit, after);
            check($sformatf("vec%0d_ledr", i), {27'd0, at_emit}, {27'd0, vecs[i].exp_ledr});
            check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            check($sformatf("vec%0d_valid_low", i), {31'd0, after[3]}, 32'd0);
        end

        // Held press beyond counter saturation: error appears only on release.
        for (int j = 0; j < 300; j++) drive(1'b1, s);
        check("long_hold_no_err", {27'd0, s}, {27'd0, 5'b00101});
        pulses = 0;
        play_letter(24'h0, at_emit, after);
        check("long_release_err", {27'd0, at_emit}, {27'd0, 5'b10101});
        check("long_pulses", pulses, 0);

        pulses = 0;
        for (int j = 0; j < 20; j++) drive(1'b0, s);
        check("idle_gap_pulses", pulses, 0);
        check("idle_gap_hold", {27'd0, s}, {27'd0, 5'b10101});

        // Reset in the middle of a letter drops the partial symbols.
        drive(1'b1, s);
        drive(1'b1, s);
        drive(1'b0, s);
        rst_n_in = 1'b0;
        #1;
        check("mid_reset_ledr", {27'd0, led_bus.ledr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n_in = 1'b1;
        pulses = 0;
        play_letter(24'h000001, at_emit, after);
        check("after_reset_E", {27'd0, at_emit}, {27'd0, 5'b01100});
        check("after_reset_pulses", pulses, 1);

        // Random letters against a duration-level model of the receiver.
        do_reset();
        for (int l = 0; l < 40; l++) begin
            bad  = 0;
            n    = 0;
            code = 0;
            li   = $urandom_range(0, 7);
            ok   = ($urandom_range(0, 1) == 1);
            p    = ok ? tlen[li] : $urandom_range(1, 5);
            for (int sidx = 0; sidx < p; sidx++) begin
                int d;
                if (ok) d = ((tcode[li] >> (tlen[li] - 1 - sidx)) & 1) != 0 ? $urandom_range(2, 4) : 1;
                else d = $urandom_range(1, 6);
                if (sidx > 0) repeat ($urandom_range(1, 2)) kq.push_back(1'b0);
                repeat (d) kq.push_back(1'b1);
                if (d > 4 || n == 4) bad = 1;
                else begin
                    code = code * 2 + ((d >= 2) ? 1 : 0);
                    n++;
                end
            end
            ev.idx  = kq.size() + 4;
            ev.ok   = 0;
            ev.code = 3'd0;
            for (int j = 0; j < 8; j++)
                if (!bad && tlen[j] == n && tcode[j] == code) begin
                    ev.ok   = 1;
                    ev.code = 3'(j);
                end
            evq.push_back(ev);
            repeat ($urandom_range(3, 6)) kq.push_back(1'b0);
        end
        repeat (8) kq.push_back(1'b0);

        ei = 0;
        hl = 3'd0;
        he = 1'b0;
        foreach (kq[t]) begin
            logic ev_v;
            drive(kq[t], s);
            ev_v = 1'b0;
            if (ei < evq.size() && evq[ei].idx == t) begin
                ev_v = evq[ei].ok;
                if (evq[ei].ok) begin
                    hl = evq[ei].code;
                    he = 1'b0;
                end else begin
                    he = 1'b1;
                end
                ei++;
            end
            check($sformatf("rand_ledr_t%0d", t), {27'd0, s}, {27'd0, he, ev_v, hl});
        end
        check("rand_events_seen", ei, evq.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
